// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Writeback source selects and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: picks byte/half/word from the raw
// memory word and sign/zero-extends it.
// Ports: funct3_i, off_i (byte offset), word_i -> data_o.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[7:0];
    unique case (off_i)
      2'd0: byte_w = word_i[7:0];
      2'd1: byte_w = word_i[15:8];
      2'd2: byte_w = word_i[23:16];
      2'd3: byte_w = word_i[31:24];
      default: byte_w = word_i[7:0];
    endcase
  end

  // off_i[0] is ignored for halfwords.
  assign half_w = off_i[1] ? word_i[31:16]
                           : word_i[15:0];

  always_comb begin
    data_o = word_i;
    unique case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_w};
      F3_LH:  data_o = {{(XLEN-16){half_w[15]}}, half_w};
      F3_LHU: data_o = {{(XLEN-16){1'b0}}, half_w};
      F3_LW:  data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register and register-file write driver; counts
// retired instructions. Optional macro WB_BYPASS_EN adds a
// write-to-read bypass (DecAddrA/B, DecDataA/B -> FwdDataA/B).
// Inputs: clk, rst, Mem* fields, Stall, Flush.
// Outputs: AddrD, RegWEn, DataD, WbValid, InstRet.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
`ifdef WB_BYPASS_EN
  input  logic [4:0]       DecAddrA,
  input  logic [4:0]       DecAddrB,
  input  logic [XLEN-1:0]  DecDataA,
  input  logic [XLEN-1:0]  DecDataB,
  output logic [XLEN-1:0]  FwdDataA,
  output logic [XLEN-1:0]  FwdDataB,
`endif
  input  logic             MemValid,
  input  logic [4:0]       MemRd,
  input  logic             MemRegWEn,
  input  logic [1:0]       MemWbSel,
  input  logic [2:0]       MemFunct3,
  input  logic [XLEN-1:0]  MemAlu,
  input  logic [XLEN-1:0]  MemPc4,
  input  logic [XLEN-1:0]  MemRdata,
  input  logic             Stall,
  input  logic             Flush,
  output logic [4:0]       AddrD,
  output logic             RegWEn,
  output logic [XLEN-1:0]  DataD,
  output logic             WbValid,
  output logic [CNT_W-1:0] InstRet
);

  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  wb_data;

  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  logic             wen_q, wen_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i (MemFunct3),
    .off_i    (MemAlu[1:0]),
    .word_i   (MemRdata),
    .data_o   (ld_data)
  );

  always_comb begin
    wb_data = '0;
    unique case (MemWbSel)
      WB_SEL_ALU: wb_data = MemAlu;
      WB_SEL_MEM: wb_data = ld_data;
      WB_SEL_PC4: wb_data = MemPc4;
      default:    wb_data = '0;
    endcase
  end

  // Flush only has to clear valid; the rest may hold.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    data_d  = data_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (!Stall) begin
      valid_d = MemValid;
      rd_d    = MemRd;
      wen_d   = MemRegWEn;
      data_d  = wb_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !Stall)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign AddrD   = rd_q;
  assign DataD   = data_q;
  assign WbValid = valid_q;
  assign InstRet = cnt_q;
  // x0 writes never reach the register file.
  assign RegWEn  = valid_q & wen_q & (rd_q != 5'd0);

`ifdef WB_BYPASS_EN
  assign FwdDataA = (RegWEn && AddrD == DecAddrA)
                  ? DataD : DecDataA;
  assign FwdDataB = (RegWEn && AddrD == DecAddrB)
                  ? DataD : DecDataB;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Optional macro WB_BYPASS_EN exercises the bypass ports.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        MemValid;
  logic [4:0]  MemRd;
  logic        MemRegWEn;
  logic [1:0]  MemWbSel;
  logic [2:0]  MemFunct3;
  logic [31:0] MemAlu;
  logic [31:0] MemPc4;
  logic [31:0] MemRdata;
  logic        Stall;
  logic        Flush;
  logic [4:0]  AddrD;
  logic        RegWEn;
  logic [31:0] DataD;
  logic        WbValid;
  logic [63:0] InstRet;
`ifdef WB_BYPASS_EN
  logic [4:0]  DecAddrA, DecAddrB;
  logic [31:0] DecDataA, DecDataB;
  logic [31:0] FwdDataA, FwdDataB;
`endif

  int n_cmp;
  int n_bad;
  int cnt;
  bit ev;

  wb_stage dut (
    .clk       (clk),
    .rst       (rst),
`ifdef WB_BYPASS_EN
    .DecAddrA  (DecAddrA),
    .DecAddrB  (DecAddrB),
    .DecDataA  (DecDataA),
    .DecDataB  (DecDataB),
    .FwdDataA  (FwdDataA),
    .FwdDataB  (FwdDataB),
`endif
    .MemValid  (MemValid),
    .MemRd     (MemRd),
    .MemRegWEn (MemRegWEn),
    .MemWbSel  (MemWbSel),
    .MemFunct3 (MemFunct3),
    .MemAlu    (MemAlu),
    .MemPc4    (MemPc4),
    .MemRdata  (MemRdata),
    .Stall     (Stall),
    .Flush     (Flush),
    .AddrD     (AddrD),
    .RegWEn    (RegWEn),
    .DataD     (DataD),
    .WbValid   (WbValid),
    .InstRet   (InstRet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Tiny retire-count model advanced once per edge.
  task automatic step();
    if (ev && !Stall) cnt++;
    ev = Flush ? 1'b0 : (Stall ? ev : MemValid);
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v,
                     input logic [4:0] rd,
                     input logic [1:0] sel,
                     input logic [2:0] f3,
                     input logic [31:0] alu,
                     input logic [31:0] rdat);
    MemValid  = v;
    MemRd     = rd;
    MemRegWEn = 1'b1;
    MemWbSel  = sel;
    MemFunct3 = f3;
    MemAlu    = alu;
    MemRdata  = rdat;
  endtask

  task automatic ld(input string tag,
                    input logic [2:0] f3,
                    input logic [31:0] alu,
                    input logic [31:0] rdat,
                    input logic [31:0] exp);
    mem(1'b1, 5'd3, WB_SEL_MEM, f3, alu, rdat);
    step();
    chk(tag, {32'd0, DataD}, {32'd0, exp});
    chk({tag, "_cnt"}, InstRet, 64'(cnt));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cnt = 0; ev = 1'b0;
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    MemPc4 = 32'h0000_0104;
    mem(1'b0, 5'd0, WB_SEL_ALU, F3_LW, 32'd0, 32'd0);
    MemRegWEn = 1'b0;
`ifdef WB_BYPASS_EN
    DecAddrA = 5'd0; DecAddrB = 5'd0;
    DecDataA = 32'hA5A5_A5A5; DecDataB = 32'h5A5A_5A5A;
`endif
    #12;
    chk("rst_valid", {63'd0, WbValid}, 64'd0);
    chk("rst_wen", {63'd0, RegWEn}, 64'd0);
    chk("rst_addr", {59'd0, AddrD}, 64'd0);
    chk("rst_data", {32'd0, DataD}, 64'd0);
    chk("rst_cnt", InstRet, 64'd0);
    rst = 1'b0;

    mem(1'b1, 5'd5, WB_SEL_ALU, F3_LW, 32'h1234, 32'd0);
    step();
    chk("alu_addr", {59'd0, AddrD}, 64'd5);
    chk("alu_data", {32'd0, DataD}, 64'h1234);
    chk("alu_wen", {63'd0, RegWEn}, 64'd1);
    MemValid = 1'b0;
    step();
    chk("alu_cnt", InstRet, 64'd1);
    chk("idle_wen", {63'd0, RegWEn}, 64'd0);

    ld("lb_off3",  F3_LB,  32'h3, 32'h80FF7F01, 32'hFFFFFF80);
    ld("lbu_off3", F3_LBU, 32'h3, 32'h80FF7F01, 32'h00000080);
    ld("lb_off0",  F3_LB,  32'h0, 32'h80FF7F01, 32'h00000001);
    ld("lb_off2",  F3_LB,  32'h2, 32'h80FF7F01, 32'hFFFFFFFF);
    ld("lbu_off1", F3_LBU, 32'h1, 32'h80FF7F01, 32'h0000007F);
    ld("lh_off2",  F3_LH,  32'h2, 32'h80010000, 32'hFFFF8001);
    ld("lhu_off2", F3_LHU, 32'h2, 32'h80010000, 32'h00008001);
    ld("lh_off3",  F3_LH,  32'h3, 32'h80010000, 32'hFFFF8001);
    ld("lh_off0",  F3_LH,  32'h0, 32'h0000F00F, 32'hFFFFF00F);
    ld("lw_off1",  F3_LW,  32'h1, 32'h80010000, 32'h80010000);

    mem(1'b1, 5'd6, WB_SEL_PC4, F3_LW, 32'h99, 32'd0);
    step();
    chk("pc4_data", {32'd0, DataD}, 64'h104);
    mem(1'b1, 5'd6, WB_SEL_RSV, F3_LW, 32'h99, 32'hFF);
    step();
    chk("rsv_data", {32'd0, DataD}, 64'd0);

    mem(1'b1, 5'd0, WB_SEL_ALU, F3_LW, 32'h77, 32'd0);
    step();
    chk("x0_wen", {63'd0, RegWEn}, 64'd0);
    chk("x0_valid", {63'd0, WbValid}, 64'd1);
    MemValid = 1'b0;
    step();
    chk("x0_cnt", InstRet, 64'(cnt));

    mem(1'b1, 5'd9, WB_SEL_ALU, F3_LW, 32'hAA, 32'd0);
    step();
    mem(1'b1, 5'd10, WB_SEL_ALU, F3_LW, 32'hBB, 32'd0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_addr", {59'd0, AddrD}, 64'd9);
      chk("stl_data", {32'd0, DataD}, 64'hAA);
      chk("stl_wen", {63'd0, RegWEn}, 64'd1);
      chk("stl_cnt", InstRet, 64'(cnt));
    end
`ifdef WB_BYPASS_EN
    DecAddrA = 5'd9; DecAddrB = 5'd8;
    #1;
    chk("fwd_a", {32'd0, FwdDataA}, 64'hAA);
    chk("fwd_b", {32'd0, FwdDataB}, 64'h5A5A5A5A);
`endif
    Flush = 1'b1;
    step();
    chk("fl_valid", {63'd0, WbValid}, 64'd0);
    chk("fl_wen", {63'd0, RegWEn}, 64'd0);
    chk("fl_cnt", InstRet, 64'(cnt));
    Flush = 1'b0; Stall = 1'b0;

    mem(1'b1, 5'd4, WB_SEL_ALU, F3_LW, 32'h55, 32'd0);
    step();
    chk("pre_rst_v", {63'd0, WbValid}, 64'd1);
    Stall = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, WbValid}, 64'd0);
    chk("ar_wen", {63'd0, RegWEn}, 64'd0);
    chk("ar_addr", {59'd0, AddrD}, 64'd0);
    chk("ar_data", {32'd0, DataD}, 64'd0);
    chk("ar_cnt", InstRet, 64'd0);
    #1 rst = 1'b0;
    Stall = 1'b0;
    cnt = 0; ev = 1'b0;
    mem(1'b1, 5'd7, WB_SEL_ALU, F3_LW, 32'h66, 32'd0);
    step();
    chk("post_addr", {59'd0, AddrD}, 64'd7);
    chk("post_data", {32'd0, DataD}, 64'h66);
    chk("post_cnt", InstRet, 64'd0);
    MemValid = 1'b0;
    step();
    chk("post_cnt2", InstRet, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
